layer_sequencer: RTL and testbench

Controller for one fully-connected layer of `neuron` instances. It accepts an input vector over a valid/ready stream into a local buffer, then broadcasts it to all neurons of the layer as a gap-free `myinputvalid` burst. It collects each neuron's `outvalid`/`output_data` result and streams the layer result vector out over valid/ready. It sits between consecutive layers, or between the input source and layer 1, so that all neurons share a single input bus.

---
 rtl/layer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_layer_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: buffers one input vector, broadcasts it to every neuron of a
// fully-connected layer as a gap-free burst, collects the per-neuron results and
// streams them out in neuron-index order.
//
// Handshakes: a word moves on either stream only in a cycle where both valid and
// ready are high at the rising edge of clk. A producer holds its data stable
// while valid is high and ready is low.
module layer_sequencer #(
    parameter int num_inputs  = 784,
    parameter int num_neurons = 30,
    parameter int data_width  = 16,
    parameter int wait_limit  = 64,
    localparam int IDX_W      = (num_neurons > 1) ? $clog2(num_neurons) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [data_width-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [data_width-1:0]             neuron_in,
    output logic                              neuron_in_valid,
    input  logic [num_neurons*data_width-1:0] neuron_out,
    input  logic [num_neurons-1:0]            neuron_outvalid,
    output logic [data_width-1:0]             out_data,
    output logic [IDX_W-1:0]                  out_index,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              timeout_err
);
    localparam int WR_W = (num_inputs > 1) ? $clog2(num_inputs) : 1;
    localparam int RD_W = $clog2(num_inputs + 1);
    localparam int WT_W = $clog2(wait_limit + 1);

    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(num_inputs - 1);
    localparam logic [RD_W-1:0]  RD_END   = RD_W'(num_inputs);
    localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(wait_limit - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(num_neurons - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_BCAST = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WR_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [RD_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [WT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [num_neurons-1:0] got_q, got_d;
    logic [data_width-1:0] res_q [num_neurons];
    logic [data_width-1:0] res_d [num_neurons];
    logic [data_width-1:0] nin_q, nin_d;
    logic                  nin_valid_q, nin_valid_d;
    logic                  terr_q, terr_d;
    logic [data_width-1:0] buf_mem [num_inputs];
    logic                  buf_we;
    logic                  cap_en;

    // Result capture runs through WAIT and also on the final BCAST cycle.
    assign cap_en = (state_q == S_WAIT) || ((state_q == S_BCAST) && (rd_cnt_q == RD_END));

    // Next-state, counters, capture and broadcast word selection.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        rd_idx_d    = rd_idx_q;
        got_d       = got_q;
        res_d       = res_q;
        nin_d       = nin_q;
        nin_valid_d = 1'b0;
        terr_d      = terr_q;
        buf_we      = 1'b0;

        for (int k = 0; k < num_neurons; k++) begin
            if (cap_en && neuron_outvalid[k]) begin
                res_d[k] = neuron_out[k*data_width +: data_width];
                got_d[k] = 1'b1;
            end
        end

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (wr_cnt_q == WR_LAST) begin
                        state_d  = S_BCAST;
                        rd_cnt_d = '0;
                        got_d    = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + WR_W'(1);
                    end
                end
            end
            S_BCAST: begin
                if (rd_cnt_q != RD_END) begin
                    nin_d       = buf_mem[rd_cnt_q[WR_W-1:0]];
                    nin_valid_d = 1'b1;
                    rd_cnt_d    = rd_cnt_q + RD_W'(1);
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (&got_d) begin
                    state_d  = S_DRAIN;
                    rd_idx_d = '0;
                end else if (wait_cnt_q == WT_LAST) begin
                    state_d  = S_DRAIN;
                    rd_idx_d = '0;
                    terr_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WT_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == IDX_LAST) begin
                        state_d  = S_LOAD;
                        rd_idx_d = '0;
                        wr_cnt_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            rd_idx_q    <= '0;
            got_q       <= '0;
            nin_q       <= '0;
            nin_valid_q <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_idx_q    <= rd_idx_d;
            got_q       <= got_d;
            nin_q       <= nin_d;
            nin_valid_q <= nin_valid_d;
            terr_q      <= terr_d;
        end
    end

    // Result words need no reset: entries not flagged in got read as zero.
    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    // Input vector buffer, written only by accepted LOAD beats.
    always_ff @(posedge clk) begin
        if (buf_we && !rst) begin
            buf_mem[wr_cnt_q] <= in_data;
        end
    end

    assign in_ready        = (state_q == S_LOAD);
    assign busy            = (state_q != S_LOAD);
    assign neuron_in       = nin_q;
    assign neuron_in_valid = nin_valid_q;
    assign out_valid       = (state_q == S_DRAIN);
    assign out_index       = rd_idx_q;
    assign out_last        = out_valid && (rd_idx_q == IDX_LAST);
    assign out_data        = (out_valid && got_q[rd_idx_q]) ? res_q[rd_idx_q] : '0;
    assign timeout_err     = terr_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a 4-input, 3-neuron layer.
module tb_layer_sequencer;
    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int WL = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  in_data;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  neuron_in;
    logic           neuron_in_valid;
    logic [NN*DW-1:0] neuron_out;
    logic [NN-1:0]  neuron_outvalid;
    logic [DW-1:0]  out_data;
    logic [1:0]     out_index;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           timeout_err;

    int compared   = 0;
    int mismatched = 0;

    layer_sequencer #(
        .num_inputs(NI), .num_neurons(NN), .data_width(DW), .wait_limit(WL)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
        .neuron_out(neuron_out), .neuron_outvalid(neuron_outvalid),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Clock
    always #5 clk = ~clk;

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0][15:0] v);
        for (int i = 0; i < NI; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            chk("load_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Called in the cycle right after the last accepted beat; returns in WAIT cycle 0.
    task automatic bcast(input logic [3:0][15:0] v);
        chk("bc_gap_valid", neuron_in_valid, 0);
        chk("bc_gap_in_ready", in_ready, 0);
        for (int i = 0; i < NI; i++) begin
            tick();
            chk("bc_valid", neuron_in_valid, 1);
            chk("bc_data", neuron_in, v[i]);
            chk("bc_in_ready", in_ready, 0);
        end
        tick();
        chk("bc_end_valid", neuron_in_valid, 0);
        chk("bc_end_busy", busy, 1);
    endtask

    task automatic results(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        neuron_out      = {c, b, a};
        neuron_outvalid = 3'b111;
        tick();
        neuron_outvalid = 3'b000;
    endtask

    task automatic drain(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        logic [15:0] e [3];
        e[0] = a; e[1] = b; e[2] = c;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NN; i++) begin
            chk("dr_valid", out_valid, 1);
            chk("dr_data", out_data, e[i]);
            chk("dr_index", out_index, i);
            chk("dr_last", out_last, (i == NN - 1));
            tick();
        end
        out_ready = 1'b0;
        chk("dr_back_in_ready", in_ready, 1);
        chk("dr_back_out_valid", out_valid, 0);
    endtask

    initial begin
        logic [15:0] sx [3];
        int          pat [4];
        int          e;

        rst = 1'b1; in_data = '0; in_valid = 1'b0;
        neuron_out = '0; neuron_outvalid = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_nin_valid", neuron_in_valid, 0);
        chk("rst_nin", neuron_in, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);

        // Load, broadcast, simultaneous results, full-speed drain
        load({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        bcast({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        chk("wait_no_out", out_valid, 0);
        results(16'h0A00, 16'h0B00, 16'h0C00);
        drain(16'h0A00, 16'h0B00, 16'h0C00);
        chk("t1_terr", timeout_err, 0);

        // Staggered results (with a repeated neuron 0) and back-pressure
        load({16'h0014, 16'h0013, 16'h0012, 16'h0011});
        bcast({16'h0014, 16'h0013, 16'h0012, 16'h0011});
        neuron_out = {16'h0, 16'h0, 16'h1111}; neuron_outvalid = 3'b001;
        tick(); neuron_outvalid = 3'b000;
        chk("stag_w1", out_valid, 0);
        tick();
        chk("stag_w2", out_valid, 0);
        tick();
        neuron_out = {16'h0, 16'h2222, 16'h1112}; neuron_outvalid = 3'b011;
        tick(); neuron_outvalid = 3'b000;
        chk("stag_w4", out_valid, 0);
        tick();
        chk("stag_w5", out_valid, 0);
        neuron_out = {16'h3333, 16'h0, 16'h0}; neuron_outvalid = 3'b100;
        tick(); neuron_outvalid = 3'b000;
        sx[0] = 16'h1112; sx[1] = 16'h2222; sx[2] = 16'h3333;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        e = 0;
        for (int c = 0; c < 20 && e < NN; c++) begin
            out_ready = pat[c % 4][0];
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, sx[e]);
            chk("bp_index", out_index, e);
            chk("bp_last", out_last, (e == NN - 1));
            tick();
            if (out_ready) e++;
        end
        out_ready = 1'b0;
        chk("bp_words_done", e, NN);
        chk("bp_back_in_ready", in_ready, 1);

        // Timeout: neuron 2 stays silent
        load({16'h0024, 16'h0023, 16'h0022, 16'h0021});
        bcast({16'h0024, 16'h0023, 16'h0022, 16'h0021});
        neuron_out = {16'h0, 16'h0E0E, 16'h0D0D}; neuron_outvalid = 3'b011;
        tick(); neuron_outvalid = 3'b000;
        for (int k = 1; k < WL; k++) begin
            chk("to_wait_valid", out_valid, 0);
            chk("to_wait_terr", timeout_err, 0);
            tick();
        end
        chk("to_terr_set", timeout_err, 1);
        drain(16'h0D0D, 16'h0E0E, 16'h0000);
        load({16'h0034, 16'h0033, 16'h0032, 16'h0031});
        chk("to_terr_sticky_load", timeout_err, 1);
        bcast({16'h0034, 16'h0033, 16'h0032, 16'h0031});
        results(16'h0101, 16'h0202, 16'h0303);
        drain(16'h0101, 16'h0202, 16'h0303);
        chk("to_terr_sticky_end", timeout_err, 1);

        // Reset on the second broadcast cycle
        load({16'h000C, 16'h000B, 16'h000A, 16'h0009});
        tick();
        chk("mr_bc_valid", neuron_in_valid, 1);
        chk("mr_bc_data", neuron_in, 16'h0009);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_nin_valid", neuron_in_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_busy", busy, 0);
        chk("mr_terr", timeout_err, 0);
        chk("mr_out_valid", out_valid, 0);

        // New vector after reset, with 0xFFFF offered during BCAST and WAIT
        load({16'h0008, 16'h0007, 16'h0006, 16'h0005});
        in_valid = 1'b1; in_data = 16'hFFFF;
        bcast({16'h0008, 16'h0007, 16'h0006, 16'h0005});
        results(16'h0505, 16'h0606, 16'h0707);
        drain(16'h0505, 16'h0606, 16'h0707);
        load({16'h0044, 16'h0043, 16'h0042, 16'h0041});
        bcast({16'h0044, 16'h0043, 16'h0042, 16'h0041});
        results(16'h0111, 16'h0222, 16'h0333);
        drain(16'h0111, 16'h0222, 16'h0333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
